serial_mag_cmp: RTL and testbench

Bit-serial magnitude comparator: accepts two unsigned W-bit operands one bit pair per accepted beat, least-significant bit first, and reports a>b, a<b or a==b once all W bits have been consumed. It is the serial, LSB-first counterpart of the team's parallel MSB-first 4-bit greater-than comparator. It sits behind serial links and shift-register datapaths where parallel operands are not available.

---
 rtl/serial_mag_cmp.sv | 74 +++++++
 tb/tb_serial_mag_cmp.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_cmp.sv
// Bit-serial LSB-first magnitude comparator: consumes W bit pairs and reports
// a>b / a<b / a==b as registered one-hot flags with a done pulse.
module serial_mag_cmp #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic bit_valid,
    input  logic a_bit,
    input  logic b_bit,
    output logic busy,
    output logic done_tick,
    output logic gt,
    output logic lt,
    output logic eq
);
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic [1:0] {V_EQ, V_GT, V_LT} verdict_t;

    state_t   state;
    verdict_t verdict, verdict_nxt;
    logic [CW-1:0] cnt;
    logic last;

    // LSB first, so every newer differing bit outranks what came before it
    always_comb begin
        verdict_nxt = verdict;
        if (a_bit != b_bit) verdict_nxt = a_bit ? V_GT : V_LT;
        last = (cnt == CW'(W - 1));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            verdict   <= V_EQ;
            cnt       <= '0;
            busy      <= 1'b0;
            done_tick <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else begin
            done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        verdict <= V_EQ;
                    end
                end
                RUN: begin
                    if (bit_valid) begin
                        verdict <= verdict_nxt;
                        cnt     <= cnt + CW'(1);
                        if (last) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            done_tick <= 1'b1;
                            gt        <= (verdict_nxt == V_GT);
                            lt        <= (verdict_nxt == V_LT);
                            eq        <= (verdict_nxt == V_EQ);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_mag_cmp.sv
// Directed + random bench for serial_mag_cmp at W=4, W=1 and W=32 with a
// result scoreboard and latency checks.
module tb_serial_mag_cmp;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start = 1'b0, bit_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0;

    logic [2:0] busy_v, done_v, gt_v, lt_v, eq_v;

    serial_mag_cmp #(.W(4)) u4 (.clk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[0]), .done_tick(done_v[0]), .gt(gt_v[0]), .lt(lt_v[0]), .eq(eq_v[0]));
    serial_mag_cmp #(.W(1)) u1 (.clk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[1]), .done_tick(done_v[1]), .gt(gt_v[1]), .lt(lt_v[1]), .eq(eq_v[1]));
    serial_mag_cmp #(.W(32)) u32 (.clk(clk), .reset_n(reset_n), .start(start), .bit_valid(bit_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy_v[2]), .done_tick(done_v[2]), .gt(gt_v[2]), .lt(lt_v[2]), .eq(eq_v[2]));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int sel = 0;
    int gap_tab [0:31];
    logic [2:0] sb_q [$];
    logic [2:0] prev_res;
    logic have_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_gaps();
        for (int i = 0; i < 32; i++) gap_tab[i] = 0;
    endtask

    // One comparison on DUT 'sel'. Returns at the negedge where done_tick must be high.
    task automatic run_cmp(input int w, input logic [31:0] a, input logic [31:0] b,
                           input bit st_mid, input bit st_last, input bit chk_lat);
        logic [31:0] am, bm;
        logic [2:0] exp, res;
        int lat;
        am = (w == 32) ? a : (a & ((32'd1 << w) - 1));
        bm = (w == 32) ? b : (b & ((32'd1 << w) - 1));
        exp = {am > bm, am < bm, am == bm};
        start = 1'b1;
        sb_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        check("busy_after_start", busy_v[sel], 1);
        if (have_prev) check("result_held_on_start", {gt_v[sel], lt_v[sel], eq_v[sel]}, prev_res);
        for (int i = 0; i < w; i++) begin
            for (int g = 0; g < gap_tab[i]; g++) begin
                bit_valid = 1'b0;
                a_bit = ~am[i];
                b_bit = am[i];
                @(negedge clk);
                lat++;
            end
            bit_valid = 1'b1;
            a_bit = am[i];
            b_bit = bm[i];
            start = (st_mid && i == 1) || (st_last && i == w - 1);
            @(negedge clk);
            lat++;
            start = 1'b0;
            if (i < w - 1) begin
                check("busy_mid", busy_v[sel], 1);
                check("no_early_done", done_v[sel], 0);
            end
        end
        bit_valid = 1'b0;
        check("done_after_last_beat", done_v[sel], 1);
        check("busy_clear_at_done", busy_v[sel], 0);
        if (chk_lat) check("latency", lat, w + 1);
        if (sb_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            exp = sb_q.pop_front();
            res = {gt_v[sel], lt_v[sel], eq_v[sel]};
            check("result_gt_lt_eq", res, exp);
            prev_res = exp;
            have_prev = 1'b1;
        end
    endtask

    task automatic check_quiet(input string tag);
        @(negedge clk);
        check({tag, "_done_low"}, done_v[sel], 0);
        check({tag, "_busy_low"}, busy_v[sel], 0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        have_prev = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        clear_gaps();
        sel = 0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_outputs", {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}, 0);

        // a=1010 b=0110, no gaps
        run_cmp(4, 32'b1010, 32'b0110, 0, 0, 1);
        check("t1_gt", {gt_v[0], lt_v[0], eq_v[0]}, 3'b100);
        check_quiet("t1_pulse");

        // a=0011 b=0101 with gaps 0,2,1,3
        gap_tab[1] = 2; gap_tab[2] = 1; gap_tab[3] = 3;
        run_cmp(4, 32'b0011, 32'b0101, 0, 0, 0);
        clear_gaps();
        check("t2_lt", {gt_v[0], lt_v[0], eq_v[0]}, 3'b010);
        check_quiet("t2_pulse");

        // equal, then back-to-back start in the done cycle
        run_cmp(4, 32'b1001, 32'b1001, 0, 0, 1);
        check("t3_eq", {gt_v[0], lt_v[0], eq_v[0]}, 3'b001);
        run_cmp(4, 32'b1111, 32'b1110, 0, 0, 1);
        check("t3_btb_gt", {gt_v[0], lt_v[0], eq_v[0]}, 3'b100);
        check_quiet("t3_pulse");

        // start during RUN and together with final beat: ignored
        run_cmp(4, 32'b0100, 32'b1000, 1, 1, 1);
        check_quiet("t4_no_restart");
        check_quiet("t4_still_idle");

        // reset after two beats
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
            @(negedge clk);
        end
        bit_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check("t5_async_reset", {busy_v[0], done_v[0], gt_v[0], lt_v[0], eq_v[0]}, 0);
        have_prev = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit_valid = 1'b1;
            @(negedge clk);
            check("t5_no_done", done_v[0], 0);
        end
        bit_valid = 1'b0;
        run_cmp(4, 32'b0110, 32'b0111, 0, 0, 1);
        check("t5_after_reset_lt", {gt_v[0], lt_v[0], eq_v[0]}, 3'b010);

        // W=1 random
        sel = 1;
        do_reset();
        for (int n = 0; n < 8; n++) begin
            run_cmp(1, $urandom, $urandom, 0, 0, 1);
            @(negedge clk);
        end

        // W=32 random plus boundary operands
        sel = 2;
        do_reset();
        run_cmp(32, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 0, 0, 1);
        @(negedge clk);
        run_cmp(32, 32'h0000_0001, 32'h8000_0000, 0, 0, 1);
        @(negedge clk);
        run_cmp(32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0, 1);
        @(negedge clk);
        for (int n = 0; n < 8; n++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (n % 3 == 0) ? ra ^ (32'd1 << $urandom_range(0, 31)) : $urandom;
            run_cmp(32, ra, rb, 0, 0, 1);
            @(negedge clk);
        end

        check("scoreboard_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
